// File: rtl/rv_pkg.sv
// Shared RV32M definitions for the execute-stage multiply/divide unit:
// funct3 encodings, FSM state encoding and the datapath width.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/execute_muldiv_unit_datapath.sv
// Radix-2 multiply/divide datapath: shift-add multiplier, restoring divider
// and final two's-complement sign correction of the selected result.
module muldiv_datapath
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_load_div,
  input  logic            i_step,
  input  logic [2:0]      i_op,
  input  logic            i_neg,
  input  logic [XLEN-1:0] i_mag_a,
  input  logic [XLEN-1:0] i_mag_b,
  output logic [XLEN-1:0] o_result
);

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  // Divide:   r_acc[31:0] shifts the dividend out and the quotient in.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_opnd;

  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_acc;
  logic [XLEN:0]     w_shift;
  logic [XLEN-1:0]   w_diff;
  logic              w_fits;
  logic [2*XLEN-1:0] w_div_acc;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem_fix;

  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_acc = {w_sum, r_acc[XLEN-1:1]};

  // The 33-bit partial remainder is always below 2*divisor, so a successful
  // subtraction leaves a value that fits in 32 bits.
  assign w_shift   = {r_rem, r_acc[XLEN-1]};
  assign w_fits    = (w_shift >= {1'b0, r_opnd});
  assign w_diff    = w_shift[XLEN-1:0] - r_opnd;
  assign w_div_acc = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_fits};

  assign w_acc_nxt = i_op[2] ? w_div_acc : w_mul_acc;
  assign w_rem_nxt = i_op[2] ? (w_fits ? w_diff : w_shift[XLEN-1:0]) : r_rem;

  // Result is taken from the post-step values so it can be registered on the
  // same edge that completes the last iteration.
  assign w_prod    = i_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quo     = i_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem_fix = i_neg ? -w_rem_nxt : w_rem_nxt;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    o_result = '0;
    case (i_op)
      M_MUL:                     o_result = w_prod[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             o_result = w_quo;
      default:                   o_result = w_rem_fix;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_rem  <= '0;
      r_opnd <= '0;
    end else if (i_load) begin
      r_acc  <= {{XLEN{1'b0}}, (i_load_div ? i_mag_a : i_mag_b)};
      r_opnd <= i_load_div ? i_mag_b : i_mag_a;
      r_rem  <= '0;
    end else if (i_step) begin
      r_acc  <= w_acc_nxt;
      r_rem  <= w_rem_nxt;
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in the execute stage: FSM, iteration
// counter, operand capture, divide fast paths and pipeline stall.
module execute_muldiv_unit
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_E,
  input  logic [2:0]      op_E,
  input  logic [XLEN-1:0] srcA_E,
  input  logic [XLEN-1:0] srcB_E,
  input  logic [4:0]      rd_E,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  md_state_e       r_state;
  logic [5:0]      r_cnt;
  logic [2:0]      r_op;
  logic            r_neg;
  logic [4:0]      r_rd;

  logic            w_accept;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_neg;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_result;
  logic [XLEN-1:0] w_dp_result;

  assign w_accept   = (r_state == MD_IDLE) && start_E && !flush;
  assign stall      = w_accept || (r_state == MD_CALC);

  assign w_a_signed = (op_E == M_MULH) || (op_E == M_MULHSU) || (op_E == M_DIV) || (op_E == M_REM);
  assign w_b_signed = (op_E == M_MULH) || (op_E == M_DIV) || (op_E == M_REM);
  assign w_sign_a   = w_a_signed && srcA_E[XLEN-1];
  assign w_sign_b   = w_b_signed && srcB_E[XLEN-1];
  assign w_mag_a    = w_sign_a ? -srcA_E : srcA_E;
  assign w_mag_b    = w_sign_b ? -srcB_E : srcB_E;
  // Remainder takes the dividend's sign; products and quotients the XOR.
  assign w_neg      = (op_E[2] && op_E[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);

  assign w_div_zero = op_E[2] && (srcB_E == '0);
  assign w_div_ovf  = ((op_E == M_DIV) || (op_E == M_REM)) &&
                      (srcA_E == 32'h8000_0000) && (srcB_E == 32'hFFFF_FFFF);
  assign w_fast     = w_div_zero || w_div_ovf;

  always_comb begin
    w_fast_result = '0;
    if (w_div_zero) w_fast_result = op_E[1] ? srcA_E : '1;
    else            w_fast_result = op_E[1] ? '0 : 32'h8000_0000;
  end

  muldiv_datapath u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept && !w_fast),
    .i_load_div (op_E[2]),
    .i_step     (r_state == MD_CALC),
    .i_op       (r_op),
    .i_neg      (r_neg),
    .i_mag_a    (w_mag_a),
    .i_mag_b    (w_mag_b),
    .o_result   (w_dp_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= MD_IDLE;
      r_cnt        <= '0;
      r_op         <= M_MUL;
      r_neg        <= 1'b0;
      r_rd         <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      result_rd    <= '0;
    end else if (flush) begin
      r_state      <= MD_IDLE;
      r_cnt        <= '0;
      result_valid <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          result_valid <= 1'b0;
          if (start_E) begin
            r_op  <= op_E;
            r_neg <= w_neg;
            r_rd  <= rd_E;
            r_cnt <= '0;
            if (w_fast) begin
              result       <= w_fast_result;
              result_rd    <= rd_E;
              result_valid <= 1'b1;
              r_state      <= MD_DONE;
            end else begin
              r_state <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            result       <= w_dp_result;
            result_rd    <= r_rd;
            result_valid <= 1'b1;
            r_state      <= MD_DONE;
          end
        end
        MD_DONE: begin
          result_valid <= 1'b0;
          r_state      <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed vector bench for execute_muldiv_unit: a table of RV32M ops with
// hand-computed results plus flush, start-ignore and mid-op reset sequences.
module tb_execute_muldiv_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_E;
  logic [2:0]  op_E;
  logic [31:0] srcA_E;
  logic [31:0] srcB_E;
  logic [4:0]  rd_E;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] prev_res;
  logic [4:0]  prev_rd;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vq[$];

  execute_muldiv_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_E      (start_E),
    .op_E         (op_E),
    .srcA_E       (srcA_E),
    .srcB_E       (srcB_E),
    .rd_E         (rd_E),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .result_rd    (result_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                     input bit fast);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.fast = fast;
    vq.push_back(v);
  endtask

  // Launch one op at cycle 0 and watch cycles 1..36 for stall, valid and result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input bit fast, input bit intrude);
    int          vcnt;
    int          vcyc;
    int          last_stall;
    int          exp_cyc;
    bit          stall_bad;
    logic [31:0] res;
    logic [4:0]  rrd;
    vcnt = 0; vcyc = -1; stall_bad = 1'b0; res = '0; rrd = '0;
    last_stall = fast ? 0 : 32;
    exp_cyc    = fast ? 1 : 33;
    @(negedge clk);
    start_E = 1'b1; op_E = op; srcA_E = a; srcB_E = b; rd_E = rd;
    #1;
    if (stall !== 1'b1) stall_bad = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      if (stall !== (k <= last_stall)) stall_bad = 1'b1;
      if (result_valid === 1'b1) begin
        vcnt++;
        if (vcyc < 0) begin vcyc = k; res = result; rrd = result_rd; end
      end
      if (k == 1) begin
        start_E = 1'b0; srcA_E = $urandom; srcB_E = $urandom; rd_E = ~rd;
      end
      if (intrude && k >= 5 && k <= 7) begin
        start_E = 1'b1; op_E = M_DIVU; srcA_E = 32'd100; srcB_E = 32'd7;
      end else if (intrude && k == 8) begin
        start_E = 1'b0;
      end
    end
    check({name, "_result"}, res, exp);
    check({name, "_rd"}, {27'd0, rrd}, {27'd0, rd});
    check({name, "_valid_cycle"}, vcyc, exp_cyc);
    check({name, "_valid_count"}, vcnt, 1);
    check({name, "_stall"}, {31'd0, stall_bad}, 32'd0);
    prev_res = exp;
    prev_rd  = rd;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start_E = 1'b0; op_E = M_MUL; srcA_E = '0; srcB_E = '0;
    rd_E = '0; flush = 1'b0;

    add("mul_7x6",        M_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         1'b0);
    add("mulh_m1xm1",     M_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0000,  1'b0);
    add("mulhu_max",      M_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'hFFFF_FFFE,  1'b0);
    add("mulhsu_m1xmax",  M_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd8,  32'hFFFF_FFFF,  1'b0);
    add("mul_max_low",    M_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  32'h0000_0001,  1'b0);
    add("mulh_m2x3",      M_MULH,   32'hFFFF_FFFE,  32'd3,          5'd10, 32'hFFFF_FFFF,  1'b0);
    add("mulhu_2p31x4",   M_MULHU,  32'h8000_0000,  32'd4,          5'd11, 32'd2,          1'b0);
    add("mul_2p16sq",     M_MUL,    32'h0001_0000,  32'h0001_0000,  5'd12, 32'd0,          1'b0);
    add("div_m7_2",       M_DIV,    32'hFFFF_FFF9,  32'd2,          5'd13, 32'hFFFF_FFFD,  1'b0);
    add("rem_m7_2",       M_REM,    32'hFFFF_FFF9,  32'd2,          5'd14, 32'hFFFF_FFFF,  1'b0);
    add("divu_100_7",     M_DIVU,   32'd100,        32'd7,          5'd15, 32'd14,         1'b0);
    add("remu_100_7",     M_REMU,   32'd100,        32'd7,          5'd16, 32'd2,          1'b0);
    add("div_7_m2",       M_DIV,    32'd7,          32'hFFFF_FFFE,  5'd17, 32'hFFFF_FFFD,  1'b0);
    add("rem_7_m2",       M_REM,    32'd7,          32'hFFFF_FFFE,  5'd18, 32'd1,          1'b0);
    add("divu_max_1",     M_DIVU,   32'hFFFF_FFFF,  32'd1,          5'd19, 32'hFFFF_FFFF,  1'b0);
    add("remu_hex_256",   M_REMU,   32'h1234_5678,  32'h0000_0100,  5'd20, 32'h0000_0078,  1'b0);
    add("divu_2p31_max",  M_DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  5'd21, 32'd0,          1'b0);
    add("remu_2p31_max",  M_REMU,   32'h8000_0000,  32'hFFFF_FFFF,  5'd22, 32'h8000_0000,  1'b0);
    add("div_min_1",      M_DIV,    32'h8000_0000,  32'd1,          5'd23, 32'h8000_0000,  1'b0);
    add("div_5_0",        M_DIV,    32'd5,          32'd0,          5'd24, 32'hFFFF_FFFF,  1'b1);
    add("remu_5_0",       M_REMU,   32'd5,          32'd0,          5'd25, 32'd5,          1'b1);
    add("rem_m7_0",       M_REM,    32'hFFFF_FFF9,  32'd0,          5'd26, 32'hFFFF_FFF9,  1'b1);
    add("div_ovf",        M_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd27, 32'h8000_0000,  1'b1);
    add("rem_ovf",        M_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd28, 32'd0,          1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_valid", {31'd0, result_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd", {27'd0, result_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i])
      run_op(vq[i].name, vq[i].op, vq[i].a, vq[i].b, vq[i].rd, vq[i].exp, vq[i].fast, 1'b0);

    // start_E raised during CALC must not disturb the op in flight.
    run_op("mul_3x5_ignore_start", M_MUL, 32'd3, 32'd5, 5'd7, 32'd15, 1'b0, 1'b1);

    // Flush at cycle 10 of a MUL: back to IDLE, no pulse, old result kept.
    @(negedge clk);
    start_E = 1'b1; op_E = M_MUL; srcA_E = 32'd9; srcB_E = 32'd9; rd_E = 5'd3;
    @(posedge clk); #1;
    start_E = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_stall_low", {31'd0, stall}, 32'd0);
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b0 || stall !== 1'b0) cnt++;
    end
    check("flush_quiet", cnt, 0);
    check("flush_result_held", result, prev_res);
    check("flush_rd_held", {27'd0, result_rd}, {27'd0, prev_rd});

    // Flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    start_E = 1'b1; flush = 1'b1; op_E = M_MUL; srcA_E = 32'd2; srcB_E = 32'd2; rd_E = 5'd4;
    #1;
    check("flush_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start_E = 1'b0; flush = 1'b0;
    cnt = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b0 || stall !== 1'b0) cnt++;
    end
    check("flush_start_quiet", cnt, 0);
    check("flush_start_result_held", result, prev_res);

    // Reset at cycle 20 of a DIV, then a fresh MUL.
    @(negedge clk);
    start_E = 1'b1; op_E = M_DIV; srcA_E = 32'd100; srcB_E = 32'd7; rd_E = 5'd11;
    @(posedge clk); #1;
    start_E = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midreset_stall", {31'd0, stall}, 32'd0);
    check("midreset_valid", {31'd0, result_valid}, 32'd0);
    check("midreset_result", result, 32'd0);
    check("midreset_rd", {27'd0, result_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_3x4_after_reset", M_MUL, 32'd3, 32'd4, 5'd9, 32'd12, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU. It consumes the execute-stage operands, ALU op and destination register straight off the decode/execute pipeline register. It holds the pipeline via `stall` while computing and returns a 32-bit result plus destination register to the execute/memory path. One operation is in flight at a time; radix-2, one bit per cycle.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk  in  1`: pipeline clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start_E  in  1`: execute-stage instruction is an M-extension op; sampled only in IDLE.
- `op_E  in  3`: funct3 of the M instruction.
- `srcA_E  in  32`: operand A (rs1).
- `srcB_E  in  32`: operand B (rs2, already forwarded).
- `rd_E  in  5`: destination register.
- `flush  in  1`: kill in-flight op (branch redirect).
- `stall  out  1`: hold the fetch, decode and execute registers.
- `result_valid  out  1`: one-cycle pulse; result/rd valid.
- `result  out  32`: M-op result, held until next accepted start.
- `result_rd  out  5`: captured `rd_E`, held with result.

## Operation
- Ops are selected by funct3:
  - 000 MUL: low 32 bits of the product.
  - 001 MULH: high 32 bits, signed×signed.
  - 010 MULHSU: high 32 bits, signed A × unsigned B.
  - 011 MULHU: high 32 bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU: quotient, signed/unsigned.
  - 110 REM, 111 REMU: remainder, signed/unsigned.
- States are IDLE, CALC and DONE. Reset enters IDLE.
- **IDLE:**
  - On `start_E=1`, capture op, rd and operand magnitudes (abs() of signed operands).
  - Record result sign: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
  - Clear the 6-bit iteration counter.
  - Go to CALC, or go directly to DONE for a fast-path case.
- **Fast path (divide ops only):**
  - B==0: quotient=0xFFFFFFFF, remainder=A.
  - Signed DIV/REM with A=0x80000000, B=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- **CALC:**
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring division with a 33-bit partial remainder.
  - Counter increments every cycle; after iteration 31, go to DONE.
- **DONE:**
  - Apply two's-complement negation when the recorded sign bit is set.
  - Register `result` and `result_rd`; pulse `result_valid`.
  - Return to IDLE next cycle.
- `start_E` while in CALC or DONE is ignored.
- `flush=1` in any state forces IDLE on the next edge; no `result_valid` is produced. `result` and `result_rd` keep their previous values.
- `flush` and `start_E` together in IDLE: flush wins, nothing is accepted.

## Timing
- Reset values: `stall=0`, `result_valid=0`, `result=0`, `result_rd=0`, state IDLE, counter 0.
- `stall` is combinational: `(IDLE & start_E & ~flush) | CALC`. It is low in DONE, so the pipeline advances in the same cycle the result is presented.
- Normal latency:
  - Start sampled at edge 0.
  - CALC during cycles 1–32.
  - `result_valid` high in cycle 33 only.
  - `stall` high in cycles 0–32.
- Fast-path latency: `result_valid` high in cycle 1; `stall` high in cycle 0 only.
- Back-to-back ops: the next start is accepted in the cycle after DONE, since DONE→IDLE takes one edge.
- Reset asserted mid-operation: immediate return to reset values; no valid pulse.

## Structure
- Shared package `rv_pkg`:
  - funct3 localparams `M_MUL … M_REMU`.
  - State enum encoding `MD_IDLE/MD_CALC/MD_DONE`.
  - `XLEN`.
- One natural sub-module: `muldiv_datapath`.
  - Contains the accumulator, partial remainder, shift logic and final sign correction.
  - The FSM, counter, `stall` and capture logic stay in the top module.

## Test plan
- MUL A=7, B=6 → `result=42`, `result_valid` only in cycle 33, `stall` high cycles 0–32, `result_rd` equals `rd_E`.
- A=B=0xFFFFFFFF: MULH → 0x00000000; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU A=100, B=7 → 14; REMU of the same operands → 2.
- DIV A=5, B=0 → 0xFFFFFFFF with valid in cycle 1; REMU A=5, B=0 → 5; DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000, REM of the same operands → 0, both fast path.
- Flush at cycle 10 of a MUL → IDLE next edge, `stall` low, no valid, prior result held. `start_E` during CALC is ignored.
- Assert `rst_n=0` at cycle 20 of a DIV → all outputs 0 immediately. A fresh MUL 3×4 after release → 12 at cycle 33.
